// File: rtl/reg_scoreboard_if.sv
// Bundles the issue, writeback, operand-check and status signals of reg_scoreboard.
// master drives the ID/WB requests; slave is the scoreboard itself.
interface reg_scoreboard_if #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
);
  logic                flush;
  logic                issue_valid;
  logic                issue_wb_en;
  logic [ADDR_W-1:0]   issue_dest;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_dest;
  logic [ADDR_W-1:0]   src1;
  logic [ADDR_W-1:0]   src2;
  logic                two_src;
  logic                hazard_detected;
  logic [NUM_REGS-1:0] busy_vec;
  logic                overflow_err;
  logic                underflow_err;

  modport master (
    output flush, issue_valid, issue_wb_en, issue_dest,
    output wb_valid, wb_dest, src1, src2, two_src,
    input  hazard_detected, busy_vec, overflow_err, underflow_err
  );

  modport slave (
    input  flush, issue_valid, issue_wb_en, issue_dest,
    input  wb_valid, wb_dest, src1, src2, two_src,
    output hazard_detected, busy_vec, overflow_err, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters for ID-stage hazard detection.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a register whose last pending write commits this cycle reads as free.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            inc_vec;
  logic [NUM_REGS-1:0]            dec_vec;
  logic [NUM_REGS-1:0]            busy_raw;
  logic [NUM_REGS-1:0]            busy_eff;
  logic                           hazard;
  logic                           ovf_hit;
  logic                           unf_hit;
  logic                           overflow_q;
  logic                           underflow_q;

  // Saturating counter step; simultaneous inc and dec cancel out even at zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    cnt_next = c;
    if (inc && !dec && (c != CNT_MAX))
      cnt_next = c + CNT_ONE;
    else if (dec && !inc && (c != CNT_ZERO))
      cnt_next = c - CNT_ONE;
  endfunction

  function automatic logic sat_overflow(input logic [CNT_W-1:0] c,
                                        input logic inc, input logic dec);
    sat_overflow = inc && !dec && (c == CNT_MAX);
  endfunction

  function automatic logic sat_underflow(input logic [CNT_W-1:0] c,
                                         input logic inc, input logic dec);
    sat_underflow = dec && !inc && (c == CNT_ZERO);
  endfunction

  always_comb begin
    dec_vec  = '0;
    busy_raw = '0;
    busy_eff = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec_vec[i]  = sb.wb_valid && (sb.wb_dest == ADDR_W'(i));
      busy_raw[i] = (cnt[i] != CNT_ZERO);
`ifdef SCOREBOARD_WB_BYPASS_EN
      busy_eff[i] = busy_raw[i] && !(dec_vec[i] && (cnt[i] == CNT_ONE));
`else
      busy_eff[i] = busy_raw[i];
`endif
    end
  end

  // Only registered counts and current sources feed the stall; issue_dest never self-stalls.
  always_comb begin
    hazard = busy_eff[sb.src1] || (sb.two_src && busy_eff[sb.src2]);
  end

  always_comb begin
    inc_vec = '0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = sb.issue_valid && sb.issue_wb_en &&
                   (sb.issue_dest == ADDR_W'(i)) && !hazard;
      ovf_hit = ovf_hit || sat_overflow(cnt[i], inc_vec[i], dec_vec[i]);
      unf_hit = unf_hit || sat_underflow(cnt[i], inc_vec[i], dec_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (sb.flush) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= cnt_next(cnt[i], inc_vec[i], dec_vec[i]);
      if (ovf_hit) overflow_q  <= 1'b1;
      if (unf_hit) underflow_q <= 1'b1;
    end
  end

  assign sb.hazard_detected = hazard;
  assign sb.busy_vec        = busy_raw;
  assign sb.overflow_err    = overflow_q;
  assign sb.underflow_err   = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, hand sequences and a randomized run against a reference model.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.ADDR_W(4), .NUM_REGS(16)) sb_if ();

  reg_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit fl, input bit iv, input bit we, input int id,
                       input bit wv, input int wd, input int s1, input int s2, input bit two);
    sb_if.flush       = fl;
    sb_if.issue_valid = iv;
    sb_if.issue_wb_en = we;
    sb_if.issue_dest  = 4'(id);
    sb_if.wb_valid    = wv;
    sb_if.wb_dest     = 4'(wd);
    sb_if.src1        = 4'(s1);
    sb_if.src2        = 4'(s2);
    sb_if.two_src     = two;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer counters per register.
  int m_cnt[16];
  bit m_ovf, m_unf;

  function automatic void m_clear_all();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic bit m_busy(input int r);
    bit wb_hit;
    wb_hit = sb_if.wb_valid && (int'(sb_if.wb_dest) == r) && (m_cnt[r] == 1);
    return (m_cnt[r] != 0) && !(BYP && wb_hit);
  endfunction

  function automatic bit m_haz();
    return m_busy(int'(sb_if.src1)) || (sb_if.two_src && m_busy(int'(sb_if.src2)));
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = (m_cnt[r] != 0);
    return v;
  endfunction

  function automatic void m_step(input bit haz);
    bit inc, dec;
    if (sb_if.flush) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      return;
    end
    for (int r = 0; r < 16; r++) begin
      inc = sb_if.issue_valid && sb_if.issue_wb_en && (int'(sb_if.issue_dest) == r) && !haz;
      dec = sb_if.wb_valid && (int'(sb_if.wb_dest) == r);
      if (inc && !dec) begin
        if (m_cnt[r] < MAXC) m_cnt[r]++;
        else m_ovf = 1;
      end else if (dec && !inc) begin
        if (m_cnt[r] > 0) m_cnt[r]--;
        else m_unf = 1;
      end
    end
  endfunction

  // Asynchronous reset pulse: asserted between edges, released one edge later.
  task automatic do_reset_assert();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic do_reset_release();
    tick();
    rst_n = 1'b1;
    m_clear_all();
  endtask

  typedef struct {
    bit fl; bit iv; bit we; int id; bit wv; int wd; int s1; int s2; bit two;
    bit          exp_haz;
    logic [15:0] exp_busy;
    bit          exp_ovf;
    bit          exp_unf;
  } vec_t;

  vec_t tbl[21];

  initial begin
    bit h;
    // fl iv we id wv wd s1 s2 two | haz busy_after ovf unf
    tbl[0]  = '{0,1,1,3, 0,0, 0,0,0, 0,    16'h0008, 0,0};
    tbl[1]  = '{0,0,0,0, 0,0, 3,0,0, 1,    16'h0008, 0,0};
    tbl[2]  = '{0,0,0,0, 0,0, 3,0,0, 1,    16'h0008, 0,0};
    tbl[3]  = '{0,0,0,0, 1,3, 3,0,0, !BYP, 16'h0000, 0,0};
    tbl[4]  = '{0,0,0,0, 0,0, 3,0,0, 0,    16'h0000, 0,0};
    tbl[5]  = '{0,1,1,5, 0,0, 0,0,0, 0,    16'h0020, 0,0};
    tbl[6]  = '{0,1,1,5, 0,0, 0,0,0, 0,    16'h0020, 0,0};
    tbl[7]  = '{0,1,1,5, 0,0, 0,0,0, 0,    16'h0020, 0,0};
    tbl[8]  = '{0,1,1,5, 0,0, 0,0,0, 0,    16'h0020, 1,0};
    tbl[9]  = '{0,0,0,0, 1,5, 0,0,0, 0,    16'h0020, 1,0};
    tbl[10] = '{0,0,0,0, 1,5, 0,0,0, 0,    16'h0020, 1,0};
    tbl[11] = '{0,0,0,0, 1,5, 0,0,0, 0,    16'h0000, 1,0};
    tbl[12] = '{0,1,1,2, 0,0, 0,0,0, 0,    16'h0004, 1,0};
    tbl[13] = '{0,0,0,0, 0,0, 0,2,0, 0,    16'h0004, 1,0};
    tbl[14] = '{0,1,1,9, 0,0, 0,2,1, 1,    16'h0004, 1,0};
    tbl[15] = '{0,0,0,0, 1,2, 0,2,1, !BYP, 16'h0000, 1,0};
    tbl[16] = '{0,0,0,0, 0,0, 0,2,1, 0,    16'h0000, 1,0};
    tbl[17] = '{0,1,1,7, 0,0, 0,0,0, 0,    16'h0080, 1,0};
    tbl[18] = '{0,1,1,7, 1,7, 0,0,0, 0,    16'h0080, 1,0};
    tbl[19] = '{0,0,0,0, 1,7, 7,0,0, !BYP, 16'h0000, 1,0};
    tbl[20] = '{0,1,1,8, 1,8, 0,0,0, 0,    16'h0000, 1,0};

    #1;
    do_reset_assert();
    chk("reset_busy", 32'(sb_if.busy_vec), 32'h0);
    chk("reset_haz",  32'(sb_if.hazard_detected), 32'h0);
    chk("reset_ovf",  32'(sb_if.overflow_err), 32'h0);
    chk("reset_unf",  32'(sb_if.underflow_err), 32'h0);
    do_reset_release();

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].we, tbl[i].id, tbl[i].wv, tbl[i].wd,
            tbl[i].s1, tbl[i].s2, tbl[i].two);
      @(negedge clk);
      chk($sformatf("tbl%0d_haz", i), 32'(sb_if.hazard_detected), 32'(tbl[i].exp_haz));
      tick();
      chk($sformatf("tbl%0d_busy", i), 32'(sb_if.busy_vec), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_ovf", i),  32'(sb_if.overflow_err), 32'(tbl[i].exp_ovf));
      chk($sformatf("tbl%0d_unf", i),  32'(sb_if.underflow_err), 32'(tbl[i].exp_unf));
    end

    // Flush beats a same-cycle issue, then a stale writeback underflows.
    do_reset_assert();
    do_reset_release();
    drive(0, 1, 1, 1,  0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 4,  0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 15, 0, 0, 0, 0, 0); tick();
    chk("flush_pre_busy", 32'(sb_if.busy_vec), 32'h8012);
    drive(1, 1, 1, 6,  0, 0, 0, 0, 0); tick();
    chk("flush_busy", 32'(sb_if.busy_vec), 32'h0);
    chk("flush_unf",  32'(sb_if.underflow_err), 32'h0);
    drive(0, 0, 0, 0,  1, 4, 0, 0, 0); tick();
    chk("stale_wb_unf",  32'(sb_if.underflow_err), 32'h1);
    chk("stale_wb_busy", 32'(sb_if.busy_vec), 32'h0);

    // Mid-stream async reset clears counters and both sticky flags before any edge.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 3, 0, 0, 0, 0, 0); tick();
    end
    drive(0, 1, 1, 10, 0, 0, 0, 0, 0); tick();
    chk("pre_rst_busy", 32'(sb_if.busy_vec), 32'h0408);
    chk("pre_rst_ovf",  32'(sb_if.overflow_err), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(sb_if.busy_vec), 32'h0);
    chk("async_rst_ovf",  32'(sb_if.overflow_err), 32'h0);
    chk("async_rst_unf",  32'(sb_if.underflow_err), 32'h0);
    chk("async_rst_haz",  32'(sb_if.hazard_detected), 32'h0);
    do_reset_release();

    // Randomized traffic over a narrow register window to provoke hazards and saturation.
    for (int blk = 0; blk < 5; blk++) begin
      do_reset_assert();
      do_reset_release();
      for (int c = 0; c < 300; c++) begin
        drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom_range(0, 1));
        @(negedge clk);
        h = m_haz();
        chk("rnd_haz", 32'(sb_if.hazard_detected), 32'(h));
        m_step(h);
        tick();
        chk("rnd_busy", 32'(sb_if.busy_vec), 32'(m_busy_vec()));
        chk("rnd_ovf",  32'(sb_if.overflow_err), 32'(m_ovf));
        chk("rnd_unf",  32'(sb_if.underflow_err), 32'(m_unf));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight destination-register writes for the ARM pipeline. It is the writer/recorder side of ID-stage hazard detection.
- ID-stage issue marks a destination pending; WB-stage commit clears it.
- ID source operands are checked against the pending set to raise a stall.
- Replaces per-stage dest comparison with a per-register in-flight counter, so pipeline depth is transparent to ID.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked (R0..R15).
- ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W.
- CNT_W, 2, per-register in-flight counter width; max outstanding writes per register = 2**CNT_W-1 (3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous clear of all pending state (branch taken).
- issue_valid  input  1  an instruction leaves ID this cycle.
- issue_wb_en  input  1  that instruction writes a register.
- issue_dest  input  ADDR_W  destination of issuing instruction.
- wb_valid  input  1  WB stage commits a register write this cycle.
- wb_dest  input  ADDR_W  register being written back.
- src1  input  ADDR_W  ID first source register.
- src2  input  ADDR_W  ID second source register.
- two_src  input  1  src2 is a real operand.
- hazard_detected  output  1  stall request to IF/ID freeze and ID/EX bubble.
- busy_vec  output  NUM_REGS  bit i = register i has ≥1 pending write.
- overflow_err  output  1  sticky: issue attempted on a saturated counter.
- underflow_err  output  1  sticky: writeback to a register with zero count.

Behaviour:
- State: cnt[i] (CNT_W bits) for each register; two sticky flags.
- Reset (rst_n=0, async): all cnt=0, overflow_err=0, underflow_err=0. Hence busy_vec=0 and hazard_detected=0.
- Increment condition: inc_i = issue_valid & issue_wb_en & (issue_dest==i) & ~hazard_detected. An issue while stalled is dropped, because the instruction stays in ID.
- Decrement condition: dec_i = wb_valid & (wb_dest==i).
- Per-register update at rising clk, highest priority first:
  - flush=1: cnt[i]<=0 for all i. Issue and wb are ignored that cycle; sticky flags are unchanged.
  - inc_i & dec_i: cnt unchanged (net zero), including when cnt=0.
  - inc_i only:
    - cnt<max: cnt+1.
    - cnt==max: cnt holds, overflow_err<=1.
  - dec_i only:
    - cnt>0: cnt-1.
    - cnt==0: cnt holds at 0, underflow_err<=1.
- Sticky flags clear only on reset.
- busy_vec[i] = (cnt[i]!=0). It is combinational from registered state, so an issue at edge N is visible from cycle N+1.
- hazard_detected = busy(src1) | (two_src & busy(src2)). It is purely combinational from current cnt and srcs.
- busy(r) uses the registered cnt only; a same-cycle wb does not clear the hazard (but see Optional Feature).
- No dependence on issue_dest in the same cycle: ID's own destination never self-stalls.
- A reset asserted mid-operation clears everything immediately; pending writebacks arriving after reset release then set underflow_err.

Optional Feature:
- SCOREBOARD_WB_BYPASS_EN
- Defined: busy(r) = (cnt[r]!=0) & ~(wb_valid & wb_dest==r & cnt[r]==1). A register whose last pending write commits this cycle is treated as free, saving one stall cycle. This requires the register file to write in the first half-cycle or provide write-through.
- Undefined: busy(r) = (cnt[r]!=0); a stall always lasts through the WB cycle.
- State update rules are identical in both builds.

Test Plan:
- Reset, then issue dest=3 at edge 1, src1=3 → busy_vec=0x0008 and hazard_detected=1 from cycle 2; wb_dest=3 at edge 4 → busy_vec=0, hazard_detected=0 from cycle 5.
- Three issues to R5 with no wb → cnt[5]=3. A fourth issue with src1≠5 → cnt stays 3, overflow_err=1. Three wbs to R5 → busy_vec[5]=0, overflow_err stays 1.
- Same-cycle issue_dest=7 and wb_dest=7 with cnt[7]=1 → cnt[7] stays 1. With the macro defined, src1=7 that cycle → hazard_detected=0; undefined → 1.
- two_src=0, src2=2, R2 pending, src1 free → hazard_detected=0; set two_src=1 → hazard_detected=1. An issue to dest=9 during that stall → cnt[9] stays 0.
- R1, R4 and R15 pending; assert flush together with issue_dest=6 → busy_vec=0 next cycle and cnt[6]=0. A subsequent wb_dest=4 → underflow_err=1.
- Pulse rst_n low mid-stream with several counters non-zero → busy_vec, overflow_err and underflow_err are all 0 immediately, before the next clk edge.
